// File: rtl/hdmi_video_timing_ctrl.sv
// Raster timing controller feeding three TMDS encoder channels (B/G/R) with DE, sync and pixels.
// Define HDMI_TIMING_TPG_EN to add the tpg_en input and the internal 8-bar colour generator.
module hdmi_video_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
`ifdef HDMI_TIMING_TPG_EN
  input  logic        tpg_en,
`endif
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  ch0_data,
  output logic [7:0]  ch1_data,
  output logic [7:0]  ch2_data,
  output logic        ch0_c0,
  output logic        ch0_c1,
  output logic        ch1_c0,
  output logic        ch1_c1,
  output logic        ch2_c0,
  output logic        ch2_c1,
  output logic        de,
  output logic        frame_start,
  output logic        underflow
);

  localparam logic [11:0] HAct       = 12'(H_ACTIVE);
  localparam logic [11:0] VAct       = 12'(V_ACTIVE);
  localparam logic [11:0] HTotal     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] VTotal     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] HSyncStart = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VSyncStart = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VSyncEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      r_state;
  logic [11:0] r_h;
  logic [11:0] r_v;
  logic [23:0] r_data;
  logic        r_de;
  logic        r_c0;
  logic        r_c1;
  logic        r_frame_start;
  logic        r_underflow;

  logic        w_run;
  logic        w_h_active;
  logic        w_active;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_first;
  logic [23:0] w_pix;
  logic        w_uf_evt;
  logic        w_ready;

  assign w_run         = (r_state == StRun);
  assign w_h_active    = (r_h < HAct);
  assign w_active      = w_run && w_h_active && (r_v < VAct);
  assign w_hsync       = w_run && (r_h >= HSyncStart) && (r_h < HSyncEnd);
  assign w_vsync       = w_run && (r_v >= VSyncStart) && (r_v < VSyncEnd);
  assign w_h_last      = (r_h == HTotal - 12'd1);
  assign w_v_last      = (r_v == VTotal - 12'd1);
  assign w_frame_first = w_run && (r_h == 12'd0) && (r_v == 12'd0);

`ifdef HDMI_TIMING_TPG_EN
  localparam int unsigned BarWInt = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [11:0] BarW    = 12'(BarWInt);

  logic [2:0]  r_bar_k;
  logic [11:0] r_bar_px;
  logic [23:0] w_bar_rgb;

  always_comb begin
    w_bar_rgb = 24'h000000;
    unique case (r_bar_k)
      3'd0: w_bar_rgb = 24'hFFFFFF;
      3'd1: w_bar_rgb = 24'hFFFF00;
      3'd2: w_bar_rgb = 24'h00FFFF;
      3'd3: w_bar_rgb = 24'h00FF00;
      3'd4: w_bar_rgb = 24'hFF00FF;
      3'd5: w_bar_rgb = 24'hFF0000;
      3'd6: w_bar_rgb = 24'h0000FF;
      3'd7: w_bar_rgb = 24'h000000;
    endcase
  end

  // Bar position restarts every line and saturates on the last bar.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bar_k  <= 3'd0;
      r_bar_px <= 12'd0;
    end else if (!w_run || w_h_last) begin
      r_bar_k  <= 3'd0;
      r_bar_px <= 12'd0;
    end else if (w_h_active) begin
      if (r_bar_px == BarW - 12'd1) begin
        r_bar_px <= 12'd0;
        if (r_bar_k != 3'd7) r_bar_k <= r_bar_k + 3'd1;
      end else begin
        r_bar_px <= r_bar_px + 12'd1;
      end
    end
  end

  always_comb begin
    w_pix    = pix_valid ? pix_data : 24'h000000;
    w_uf_evt = w_active && !pix_valid;
    w_ready  = w_active;
    if (tpg_en) begin
      w_pix    = w_bar_rgb;
      w_uf_evt = 1'b0;
      w_ready  = 1'b0;
    end
  end
`else
  always_comb begin
    w_pix    = pix_valid ? pix_data : 24'h000000;
    w_uf_evt = w_active && !pix_valid;
    w_ready  = w_active;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= StIdle;
      r_h           <= 12'd0;
      r_v           <= 12'd0;
      r_data        <= 24'h000000;
      r_de          <= 1'b0;
      r_c0          <= ~HS_POL;
      r_c1          <= ~VS_POL;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_h <= 12'd0;
          r_v <= 12'd0;
          if (enable) r_state <= StRun;
        end
        StRun: begin
          if (w_h_last) begin
            r_h <= 12'd0;
            if (w_v_last) begin
              r_v <= 12'd0;
              // Enable is only honoured on a frame boundary.
              if (!enable) r_state <= StIdle;
            end else begin
              r_v <= r_v + 12'd1;
            end
          end else begin
            r_h <= r_h + 12'd1;
          end
        end
        default: r_state <= StIdle;
      endcase

      r_de          <= w_active;
      r_data        <= w_active ? w_pix : 24'h000000;
      r_c0          <= w_hsync ? HS_POL : ~HS_POL;
      r_c1          <= w_vsync ? VS_POL : ~VS_POL;
      r_frame_start <= w_frame_first;
      // A new underflow in the frame_start cycle outranks the clear.
      r_underflow   <= w_uf_evt || (r_underflow && !w_frame_first);
    end
  end

  assign pix_ready   = w_ready;
  assign ch2_data    = r_data[23:16];
  assign ch1_data    = r_data[15:8];
  assign ch0_data    = r_data[7:0];
  assign ch0_c0      = r_c0;
  assign ch0_c1      = r_c1;
  assign ch1_c0      = 1'b0;
  assign ch1_c1      = 1'b0;
  assign ch2_c0      = 1'b0;
  assign ch2_c1      = 1'b0;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Directed bench for hdmi_video_timing_ctrl on a 8x5 raster (4x2 active, 40-cycle frame).
module tb_hdmi_video_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] pix_data = 24'h123456;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  ch0_data, ch1_data, ch2_data;
  logic        ch0_c0, ch0_c1, ch1_c0, ch1_c1, ch2_c0, ch2_c1;
  logic        de, frame_start, underflow;
`ifdef HDMI_TIMING_TPG_EN
  logic        tpg_en = 1'b0;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_uf = 1'b0;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .enable(enable),
`ifdef HDMI_TIMING_TPG_EN
    .tpg_en(tpg_en),
`endif
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .ch0_data(ch0_data),
    .ch1_data(ch1_data),
    .ch2_data(ch2_data),
    .ch0_c0(ch0_c0),
    .ch0_c1(ch0_c1),
    .ch1_c0(ch1_c0),
    .ch1_c1(ch1_c1),
    .ch2_c0(ch2_c0),
    .ch2_c1(ch2_c1),
    .de(de),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit act(input int idx);
    int h, v;
    h = idx % 8;
    v = (idx % 40) / 8;
    return (h < 4) && (v < 2);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " de"}, {31'd0, de}, 32'd0);
    chk({tag, " data"}, {8'd0, ch2_data, ch1_data, ch0_data}, 32'd0);
    chk({tag, " c0"}, {31'd0, ch0_c0}, 32'd1);
    chk({tag, " c1"}, {31'd0, ch0_c1}, 32'd1);
    chk({tag, " other_c"}, {28'd0, ch1_c0, ch1_c1, ch2_c0, ch2_c1}, 32'd0);
    chk({tag, " pix_ready"}, {31'd0, pix_ready}, 32'd0);
    chk({tag, " frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, " underflow"}, {31'd0, underflow}, 32'd0);
  endtask

  // Reset, then release together with enable; the next posedge enters the first RUN cycle.
  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    pix_valid = 1'b0;
    exp_uf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  // Iteration k: counters hold frame index c=k-1, registered outputs show index o=k-2.
  task automatic scan(input int n, input int run_limit, input int bad_c, input int drop_c,
                      input int exp_xf);
    int c, o, h, v, xf;
    bit a;
    logic        e_de, e_c0, e_c1, e_fs;
    logic [23:0] e_data;
    xf = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      c = k - 1;
      o = k - 2;
      pix_valid = (c != bad_c);
      if (c == drop_c) enable = 1'b0;
      chk($sformatf("pix_ready c%0d", c), {31'd0, pix_ready},
          {31'd0, (c < run_limit) && act(c)});
      if (pix_ready && pix_valid && c < 40) xf++;
      if (o >= 0 && o < run_limit) begin
        h = o % 8;
        v = (o % 40) / 8;
        a = act(o);
        e_de = a;
        e_data = (a && o != bad_c) ? pix_data : 24'h000000;
        e_c0 = !(h == 5 || h == 6);
        e_c1 = (v != 3);
        e_fs = (o % 40 == 0);
        if (a && o == bad_c) exp_uf = 1'b1;
        else if (e_fs) exp_uf = 1'b0;
      end else begin
        e_de = 1'b0;
        e_data = 24'h000000;
        e_c0 = 1'b1;
        e_c1 = 1'b1;
        e_fs = 1'b0;
      end
      chk($sformatf("de o%0d", o), {31'd0, de}, {31'd0, e_de});
      chk($sformatf("data o%0d", o), {8'd0, ch2_data, ch1_data, ch0_data}, {8'd0, e_data});
      chk($sformatf("hsync o%0d", o), {31'd0, ch0_c0}, {31'd0, e_c0});
      chk($sformatf("vsync o%0d", o), {31'd0, ch0_c1}, {31'd0, e_c1});
      chk($sformatf("frame_start o%0d", o), {31'd0, frame_start}, {31'd0, e_fs});
      chk($sformatf("underflow o%0d", o), {31'd0, underflow}, {31'd0, exp_uf});
      chk($sformatf("other_c o%0d", o), {28'd0, ch1_c0, ch1_c1, ch2_c0, ch2_c1}, 32'd0);
    end
    if (exp_xf >= 0) chk("transfers", xf, exp_xf);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");

    // Continuous frame with constant valid pixels, rolling into the next frame.
    pix_data = 24'h123456;
    restart();
    scan(42, 1000, -1, -1, 8);

    // Second active pixel missing: zero data, sticky underflow until next frame_start.
    pix_data = 24'hA5C33C;
    restart();
    scan(42, 1000, 1, -1, 7);

    // Enable dropped at cycle 10: the frame completes, then IDLE.
    pix_data = 24'h0F1E2D;
    restart();
    scan(46, 40, -1, 10, 8);

    // Asynchronous reset while an active pixel is on the outputs.
    pix_data = 24'h123456;
    restart();
    scan(3, 1000, -1, -1, -1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    exp_uf = 1'b0;
    scan(4, 1000, -1, -1, -1);

`ifdef HDMI_TIMING_TPG_EN
    begin
      logic [23:0] bars [4];
      bars[0] = 24'hFFFFFF;
      bars[1] = 24'hFFFF00;
      bars[2] = 24'h00FFFF;
      bars[3] = 24'h00FF00;
      restart();
      tpg_en = 1'b1;
      pix_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        chk($sformatf("tpg pix_ready k%0d", k), {31'd0, pix_ready}, 32'd0);
        if (k >= 2) begin
          chk($sformatf("tpg data o%0d", k - 2), {8'd0, ch2_data, ch1_data, ch0_data},
              {8'd0, bars[k - 2]});
          chk($sformatf("tpg underflow o%0d", k - 2), {31'd0, underflow}, 32'd0);
        end
      end
      tpg_en = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
